// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

   localparam int         PC_INC     = 4;
   // Instructions are word aligned: the low ALIGN_BITS of any fetch address are forced to ALIGN_LO.
   localparam int         ALIGN_BITS = 2;
   localparam logic [1:0] ALIGN_LO   = 2'b00;
endpackage

// File: rtl/pc_fetch_ctrl_adder.sv
// Plain modulo-2^W adder used for sequential PC advance.
module pc_fetch_ctrl_adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);
   assign sum = a + b;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer: one outstanding imem fetch, single-entry instruction buffer to decode,
// branch/jump redirect squashes in-flight or held instructions from the old path.
module pc_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                     ADDRESS_WIDTH = 32,
   parameter int                     DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_target,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_ready,
   input  logic                     imem_rvalid,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic                     inst_valid,
   output logic [DATA_WIDTH-1:0]    inst,
   output logic [ADDRESS_WIDTH-1:0] inst_pc,
   input  logic                     inst_ready,
   output logic [ADDRESS_WIDTH-1:0] PC
);
   fetch_state_t             state, state_d;
   logic [ADDRESS_WIDTH-1:0] pc, pc_d, req_pc, req_pc_d, pc_inc, tgt;
   logic [DATA_WIDTH-1:0]    inst_buf, inst_buf_d;
   logic                     kill, kill_d;
   logic                     unused_tgt_lo;

   pc_fetch_ctrl_adder #(.W(ADDRESS_WIDTH)) u_pc_add (
      .a   (pc),
      .b   (ADDRESS_WIDTH'(PC_INC)),
      .sum (pc_inc)
   );

   assign tgt           = {redirect_target[ADDRESS_WIDTH-1:ALIGN_BITS], ALIGN_LO};
   assign unused_tgt_lo = ^redirect_target[ALIGN_BITS-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_VECTOR;
         req_pc   <= '0;
         inst_buf <= '0;
         kill     <= 1'b0;
      end else begin
         state    <= state_d;
         pc       <= pc_d;
         req_pc   <= req_pc_d;
         inst_buf <= inst_buf_d;
         kill     <= kill_d;
      end
   end

   always_comb begin
      state_d    = state;
      pc_d       = pc;
      req_pc_d   = req_pc;
      inst_buf_d = inst_buf;
      kill_d     = kill;
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      inst       = '0;
      inst_pc    = '0;
      case (state)
         IDLE: state_d = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               req_pc_d = pc;
               pc_d     = pc_inc;
               state_d  = WAIT;
               // A redirect racing the accept still has a response coming; squash it.
               if (redirect_valid) kill_d = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (!kill && !redirect_valid) begin
                  inst_buf_d = imem_rdata;
                  state_d    = HOLD;
               end else begin
                  state_d = REQ;
               end
               kill_d = 1'b0;
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            inst_valid = 1'b1;
            inst       = inst_buf;
            inst_pc    = req_pc;
            if (inst_ready || redirect_valid) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
      // Redirect wins over sequential advance in every active state.
      if (redirect_valid && state != IDLE) pc_d = tgt;
   end

   assign imem_addr = pc;
   assign PC        = pc;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed + randomized bench for pc_fetch_ctrl against a transaction-level fetch model.
module tb_pc_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst, redirect_valid, imem_ready, imem_rvalid, inst_ready;
   logic [31:0] redirect_target, imem_rdata;
   logic        imem_req, inst_valid;
   logic [31:0] imem_addr, inst, inst_pc, pc_o;

   int checks   = 0;
   int failures = 0;

   // Model: "started" (out of the post-reset idle cycle), an outstanding fetch
   // that may be squashed, and an optional instruction held for decode.
   logic        m_started, m_out, m_kill, m_hold;
   logic [31:0] m_pc, m_req_pc, m_buf;
   logic [31:0] held_inst, held_pc;

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .PC(pc_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rv, input logic [31:0] rt, input logic rdy,
                        input logic rval, input logic [31:0] rd, input logic ir);
      rst = r; redirect_valid = rv; redirect_target = rt; imem_ready = rdy;
      imem_rvalid = rval; imem_rdata = rd; inst_ready = ir;
   endtask

   task automatic model_step();
      logic [31:0] npc;
      if (rst) begin
         m_started = 0; m_out = 0; m_kill = 0; m_hold = 0;
         m_pc = 32'h0; m_req_pc = 0; m_buf = 0;
      end else if (!m_started) begin
         m_started = 1;
      end else begin
         npc = m_pc;
         if (m_hold) begin
            if (redirect_valid || inst_ready) m_hold = 0;
         end else if (m_out) begin
            if (imem_rvalid) begin
               m_out = 0;
               if (!m_kill && !redirect_valid) begin m_hold = 1; m_buf = imem_rdata; end
               m_kill = 0;
            end else if (redirect_valid) m_kill = 1;
         end else if (imem_ready) begin
            m_req_pc = m_pc; m_out = 1; m_kill = redirect_valid;
            npc = m_pc + 32'd4;
         end
         if (redirect_valid) npc = redirect_target & ~32'd3;
         m_pc = npc;
      end
   endtask

   // Check every output against the model, then advance one clock.
   task automatic cycle();
      chk("imem_req",   {31'b0, imem_req},   {31'b0, m_started && !m_out && !m_hold});
      chk("imem_addr",  imem_addr,  m_pc);
      chk("pc",         pc_o,       m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
      chk("inst",       inst,       m_hold ? m_buf : 32'h0);
      chk("inst_pc",    inst_pc,    m_hold ? m_req_pc : 32'h0);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); model_step(); @(negedge clk);
      cycle();
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_pc",  pc_o, 32'h0);

      // Sequential fetch, zero-wait memory, 1-cycle response latency.
      drive(0, 0, 0, 1, 0, 0, 1);
      chk("first_req_idle", {31'b0, imem_req}, 32'h0);
      cycle();
      for (int k = 0; k < 3; k++) begin
         chk("seq_req",  {31'b0, imem_req}, 32'h1);
         chk("seq_addr", imem_addr, 32'(4 * k));
         drive(0, 0, 0, 1, 0, 0, 1); cycle();
         d = $urandom;
         drive(0, 0, 0, 0, 1, d, 1); cycle();
         chk("seq_inst_pc", inst_pc, 32'(4 * k));
         chk("seq_inst",    inst, d);
         drive(0, 0, 0, 0, 0, 0, 1); cycle();
      end

      // Decode stall for 5 cycles.
      drive(0, 0, 0, 1, 0, 0, 0); cycle();
      d = $urandom;
      drive(0, 0, 0, 0, 1, d, 0); cycle();
      held_inst = inst; held_pc = inst_pc;
      chk("stall_pc0", held_pc, 32'hC);
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 1, 0, 0, 0); cycle();
         chk("stall_inst",  inst, d);
         chk("stall_ipc",   inst_pc, 32'hC);
         chk("stall_noreq", {31'b0, imem_req}, 32'h0);
      end
      drive(0, 0, 0, 0, 0, 0, 1); cycle();
      chk("stall_next_addr", imem_addr, 32'h10);

      // Redirect during WAIT, stale response two cycles later.
      drive(0, 0, 0, 1, 0, 0, 1); cycle();
      drive(0, 1, 32'h100, 0, 0, 0, 1); cycle();
      drive(0, 0, 0, 0, 0, 0, 1); cycle();
      drive(0, 0, 0, 0, 1, 32'hDEADBEEF, 1); cycle();
      chk("redir_wait_valid", {31'b0, inst_valid}, 32'h0);
      chk("redir_wait_addr",  imem_addr, 32'h100);

      // Redirect to unaligned target on the accept cycle.
      drive(0, 1, 32'h203, 1, 0, 0, 1); cycle();
      chk("redir_req_pc", pc_o, 32'h200);
      drive(0, 0, 0, 0, 1, 32'h12345678, 1); cycle();
      chk("redir_req_valid", {31'b0, inst_valid}, 32'h0);
      chk("redir_req_addr",  imem_addr, 32'h200);

      // Address wrap at the top of memory.
      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1); cycle();
      chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
      drive(0, 0, 0, 1, 0, 0, 1); cycle();
      chk("wrap_pc", pc_o, 32'h0);
      drive(0, 0, 0, 0, 1, 32'hCAFEF00D, 0); cycle();
      chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 0, 0, 1); cycle();

      // Reset in WAIT, stale responses in IDLE and REQ.
      drive(0, 0, 0, 1, 0, 0, 1); cycle();
      drive(1, 0, 0, 0, 0, 0, 0); cycle();
      drive(0, 0, 0, 0, 1, 32'hBADBAD00, 1); cycle();
      chk("stale_idle_valid", {31'b0, inst_valid}, 32'h0);
      chk("stale_req",        {31'b0, imem_req}, 32'h1);
      chk("stale_addr",       imem_addr, 32'h0);
      drive(0, 0, 0, 0, 1, 32'hBADBAD01, 1); cycle();
      chk("stale_req_valid",  {31'b0, inst_valid}, 32'h0);
      chk("stale_req_hold",   {31'b0, imem_req}, 32'h1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
               ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom,
               $urandom_range(0, 2) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
